// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and opcode-class helpers for the
// ALU family (single-cycle core and the iterative mul/div variant).
package alu_pkg;

  localparam int ALU_OPW = 5;

  localparam logic [ALU_OPW-1:0] ALU_ADD    = 5'd0;
  localparam logic [ALU_OPW-1:0] ALU_SUB    = 5'd1;
  localparam logic [ALU_OPW-1:0] ALU_SLL    = 5'd2;
  localparam logic [ALU_OPW-1:0] ALU_SLT    = 5'd3;
  localparam logic [ALU_OPW-1:0] ALU_SLTU   = 5'd4;
  localparam logic [ALU_OPW-1:0] ALU_XOR    = 5'd5;
  localparam logic [ALU_OPW-1:0] ALU_SRL    = 5'd6;
  localparam logic [ALU_OPW-1:0] ALU_SRA    = 5'd7;
  localparam logic [ALU_OPW-1:0] ALU_OR     = 5'd8;
  localparam logic [ALU_OPW-1:0] ALU_AND    = 5'd9;
  localparam logic [ALU_OPW-1:0] ALU_MUL    = 5'd10;
  localparam logic [ALU_OPW-1:0] ALU_MULH   = 5'd11;
  localparam logic [ALU_OPW-1:0] ALU_MULHSU = 5'd12;
  localparam logic [ALU_OPW-1:0] ALU_MULHU  = 5'd13;
  localparam logic [ALU_OPW-1:0] ALU_DIV    = 5'd14;
  localparam logic [ALU_OPW-1:0] ALU_DIVU   = 5'd15;
  localparam logic [ALU_OPW-1:0] ALU_REM    = 5'd16;
  localparam logic [ALU_OPW-1:0] ALU_REMU   = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_legal(input logic [ALU_OPW-1:0] op);
    return op <= ALU_REMU;
  endfunction

  function automatic logic is_muldiv(input logic [ALU_OPW-1:0] op);
    return (op >= ALU_MUL) && (op <= ALU_REMU);
  endfunction

  function automatic logic is_div(input logic [ALU_OPW-1:0] op);
    return (op >= ALU_DIV) && (op <= ALU_REMU);
  endfunction

  // Operand a is treated as two's complement by these ops.
  function automatic logic is_signed_a(input logic [ALU_OPW-1:0] op);
    return (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  function automatic logic is_signed_b(input logic [ALU_OPW-1:0] op);
    return (op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_REM);
  endfunction

endpackage

// File: rtl/alu_base_comb.sv
// Combinational datapath for the single-cycle RV32I ALU ops plus the
// illegal-opcode flag. Non-base opcodes produce zero.
module alu_base_comb
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN),
  parameter int OPW  = ALU_OPW
) (
  input  logic [OPW-1:0]  op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] y_o,
  output logic            illegal_o
);

  logic [SHW-1:0] shamt;
  logic           lt_s;
  logic           lt_u;

  assign shamt = b_i[SHW-1:0];
  assign lt_s  = $signed(a_i) < $signed(b_i);
  assign lt_u  = a_i < b_i;

  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_ADD:  y_o = a_i + b_i;
      ALU_SUB:  y_o = a_i - b_i;
      ALU_SLL:  y_o = a_i << shamt;
      ALU_SLT:  y_o = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: y_o = {{(XLEN-1){1'b0}}, lt_u};
      ALU_XOR:  y_o = a_i ^ b_i;
      ALU_SRL:  y_o = a_i >> shamt;
      ALU_SRA:  y_o = $signed(a_i) >>> shamt;
      ALU_OR:   y_o = a_i | b_i;
      ALU_AND:  y_o = a_i & b_i;
      default:  y_o = '0;
    endcase
  end

  assign illegal_o = !is_legal(op_i);

endmodule

// File: rtl/alu_mdu_iter.sv
// RV32I ALU plus iterative RV32M multiply/divide behind a valid/ready
// handshake; base ops take one cycle, MUL*/DIV*/REM* take XLEN cycles.
module alu_mdu_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN),
  parameter int OPW  = ALU_OPW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] y,
  output logic            zero,
  output logic            illegal,
  output logic [1:0]      dbg_state
);

  // Handshake: a request transfers on in_valid && in_ready, a result on
  // out_valid && out_ready; y/zero/illegal are registers and hold until
  // the next accepted op writes them, so they are stable under backpressure.

  state_e            state_q, state_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [OPW-1:0]    op_q, op_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic [XLEN-1:0]   y_q, y_d;
  logic              zero_q, zero_d;
  logic              ill_q, ill_d;

  logic [XLEN-1:0]   base_y;
  logic              base_ill;

  alu_base_comb #(
    .XLEN(XLEN),
    .SHW (SHW),
    .OPW (OPW)
  ) u_base (
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .y_o      (base_y),
    .illegal_o(base_ill)
  );

  logic            sa, sb, b_nz;
  logic [XLEN-1:0] mag_a, mag_b;

  assign sa    = is_signed_a(op) & a[XLEN-1];
  assign sb    = is_signed_b(op) & b[XLEN-1];
  assign mag_a = sa ? -a : a;
  assign mag_b = sb ? -b : b;
  assign b_nz  = |b;

  // Single XLEN+1-bit adder with carry-out, shared by shift-add multiply
  // and the trial subtraction of the restoring divide.
  logic [XLEN:0]   shift_div;
  logic [XLEN:0]   add_x, add_y;
  logic            add_cin;
  logic [XLEN+1:0] add_s;

  assign shift_div = {acc_q, lo_q[XLEN-1]};

  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    if (state_q == ST_DIV) begin
      add_x   = shift_div;
      add_y   = ~{1'b0, opb_q};
      add_cin = 1'b1;
    end else begin
      add_x   = {1'b0, acc_q};
      add_y   = lo_q[0] ? {1'b0, opb_q} : '0;
    end
  end

  assign add_s = {1'b0, add_x} + {1'b0, add_y} + {{(XLEN+1){1'b0}}, add_cin};

  logic              div_ge;
  logic [XLEN-1:0]   iter_acc, iter_lo;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fin_y;

  assign div_ge = add_s[XLEN+1];

  always_comb begin
    if (state_q == ST_DIV) begin
      iter_acc = div_ge ? add_s[XLEN-1:0] : shift_div[XLEN-1:0];
      iter_lo  = {lo_q[XLEN-2:0], div_ge};
    end else begin
      iter_acc = add_s[XLEN:1];
      iter_lo  = {add_s[0], lo_q[XLEN-1:1]};
    end
  end

  assign prod     = {iter_acc, iter_lo};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -iter_lo : iter_lo;
  assign rem_fix  = rneg_q ? -iter_acc : iter_acc;

  always_comb begin
    fin_y = rem_fix;
    case (op_q)
      ALU_MUL:                          fin_y = prod_fix[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU:  fin_y = prod_fix[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU:                fin_y = quo_fix;
      default:                          fin_y = rem_fix;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    y_d       = y_q;
    zero_d    = zero_q;
    ill_d     = ill_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_MUL, ST_DIV: begin
        acc_d = iter_acc;
        lo_d  = iter_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(XLEN-1)) begin
          y_d     = fin_y;
          zero_d  = (fin_y == '0);
          ill_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (in_valid && in_ready) begin
      op_d  = op;
      cnt_d = '0;
      if (is_muldiv(op)) begin
        acc_d  = '0;
        lo_d   = is_div(op) ? mag_a : mag_b;
        opb_d  = is_div(op) ? mag_b : mag_a;
        // Divide by zero keeps the all-ones quotient unsigned.
        neg_d  = (sa ^ sb) && (!is_div(op) || b_nz);
        rneg_d = sa;
        state_d = is_div(op) ? ST_DIV : ST_MUL;
      end else begin
        y_d     = base_y;
        zero_d  = (base_y == '0);
        ill_d   = base_ill;
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      y_q     <= '0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
    end
  end

  assign y         = y_q;
  assign zero      = zero_q;
  assign illegal   = ill_q;
  assign dbg_state = state_q;

endmodule
